// File: rtl/inv_byte_sub_seq_if.sv
`default_nettype none
// ============================================================================
// inv_byte_sub_seq_if : valid/ready input and output channels of the engine
// Rev 1.0
// ============================================================================
interface inv_byte_sub_seq_if #(
   parameter int WIDTH = 128
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] data_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] data_o;

   modport slave (
      input  in_valid_i, data_i, out_ready_i,
      output in_ready_o, out_valid_o, data_o
   );

   modport master (
      output in_valid_i, data_i, out_ready_i,
      input  in_ready_o, out_valid_o, data_o
   );
endinterface
`default_nettype wire

// File: rtl/inv_byte_sub_seq.sv
`default_nettype none
// ============================================================================
// inv_byte_sub_seq : AES inverse SubBytes, LANES bytes per clock, MSB byte first
// Rev 1.0
// ============================================================================
module inv_byte_sub_seq #(
   parameter int WIDTH = 128,
   parameter int LANES = 4
) (
   input  wire logic          clk_i,
   input  wire logic          rst_i,
   inv_byte_sub_seq_if.slave  bus
);
   localparam int N  = WIDTH / (8 * LANES);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] c_last = CW'(N - 1);

   // Inverse S-box, entry 0x00 in the top byte
   localparam logic [2047:0] c_inv_sbox = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [7:0]       w_lane_in  [LANES];
   logic [7:0]       w_lane_out [LANES];

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return c_inv_sbox[2047 - 8*int'(b) -: 8];
   endfunction

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_lane_in[l]  = work_q[WIDTH - 8 - 8*(int'(cnt_q)*LANES + l) +: 8];
      assign w_lane_out[l] = inv_sbox(w_lane_in[l]);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid_i) begin
               work_d  = bus.data_i;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            for (int l = 0; l < LANES; l++) begin
               work_d[WIDTH - 8 - 8*(int'(cnt_q)*LANES + l) +: 8] = w_lane_out[l];
            end
            if (cnt_q == c_last) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            // Release returns to IDLE only, so no accept can share the release edge
            if (bus.out_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
      end
   end

   assign bus.in_ready_o  = (state_q == S_IDLE);
   assign bus.out_valid_o = (state_q == S_DONE);
   assign bus.data_o      = work_q;
endmodule
`default_nettype wire

// File: tb/tb_inv_byte_sub_seq.sv
`default_nettype none
// ============================================================================
// tb_inv_byte_sub_seq : directed bench for the sequential inverse SubBytes engine
// Rev 1.0
// ============================================================================
module tb_inv_byte_sub_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   inv_byte_sub_seq_if #(.WIDTH(128)) bus4  ();
   inv_byte_sub_seq_if #(.WIDTH(128)) bus1  ();
   inv_byte_sub_seq_if #(.WIDTH(128)) bus16 ();

   inv_byte_sub_seq #(.WIDTH(128), .LANES(4))  dut4  (.clk_i(clk), .rst_i(rst), .bus(bus4));
   inv_byte_sub_seq #(.WIDTH(128), .LANES(1))  dut1  (.clk_i(clk), .rst_i(rst), .bus(bus1));
   inv_byte_sub_seq #(.WIDTH(128), .LANES(16)) dut16 (.clk_i(clk), .rst_i(rst), .bus(bus16));

   localparam logic [127:0] c_known_in  = 128'h87c9be63f26e5363_6363636363636363;
   localparam logic [127:0] c_known_exp = 128'hea125a0004455000_0000000000000000;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Forward S-box built from GF(2^8) inversion plus the affine map
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] fsbox(input logic [7:0] a);
      logic [7:0] v = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(a, 8'(c)) == 8'h01) v = 8'(c);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   task automatic drv(input int sel, input logic v, input logic [127:0] d, input logic ordy);
      case (sel)
         1:       begin bus1.in_valid_i  = v; bus1.data_i  = d; bus1.out_ready_i  = ordy; end
         16:      begin bus16.in_valid_i = v; bus16.data_i = d; bus16.out_ready_i = ordy; end
         default: begin bus4.in_valid_i  = v; bus4.data_i  = d; bus4.out_ready_i  = ordy; end
      endcase
   endtask

   function automatic logic rdy(input int sel);
      return (sel == 1) ? bus1.in_ready_o : (sel == 16) ? bus16.in_ready_o : bus4.in_ready_o;
   endfunction

   function automatic logic vld(input int sel);
      return (sel == 1) ? bus1.out_valid_o : (sel == 16) ? bus16.out_valid_o : bus4.out_valid_o;
   endfunction

   function automatic logic [127:0] dat(input int sel);
      return (sel == 1) ? bus1.data_o : (sel == 16) ? bus16.data_o : bus4.data_o;
   endfunction

   task automatic run_block(input int sel, input logic [127:0] din, input logic [127:0] exp,
                            input int lat_exp, input string tag);
      int w;
      int lat;
      w = 0;
      drv(sel, 1'b1, din, 1'b1);
      while (!rdy(sel) && w < 50) begin tick(); w++; end
      chk({tag, " ready"}, 128'(rdy(sel)), 128'd1);
      tick();
      drv(sel, 1'b0, din, 1'b1);
      chk({tag, " busy"}, 128'(rdy(sel)), 128'd0);
      lat = 0;
      while (lat < 100) begin
         tick();
         lat++;
         if (vld(sel)) break;
      end
      chk({tag, " latency"}, 128'(lat), 128'(lat_exp));
      chk({tag, " data"}, dat(sel), exp);
      tick();
      chk({tag, " release"}, {126'd0, vld(sel), rdy(sel)}, 128'd1);
   endtask

   logic [127:0] din, dexp;
   logic [127:0] expq[$];
   int           acc_t[$];
   int           t, nacc, nout, w;
   logic         acc, seen;

   initial begin
      drv(4, 1'b0, '0, 1'b0);
      drv(1, 1'b0, '0, 1'b0);
      drv(16, 1'b0, '0, 1'b0);

      // Reset, then a request while reset is still asserted
      rst = 1'b1;
      tick(); tick();
      chk("reset out_valid", 128'(bus4.out_valid_o), 128'd0);
      chk("reset in_ready", 128'(bus4.in_ready_o), 128'd1);
      chk("reset data_o", bus4.data_o, 128'd0);
      drv(4, 1'b1, c_known_in, 1'b1);
      tick();
      chk("valid under reset ignored", {126'd0, bus4.in_ready_o, bus4.out_valid_o}, 128'd2);
      rst = 1'b0;
      run_block(4, c_known_in, c_known_exp, 4, "known L4");

      // Every byte value, fed as S-box of a counting pattern
      for (int b = 0; b < 16; b++) begin
         for (int j = 0; j < 16; j++) begin
            din[127 - 8*j -: 8]  = fsbox(8'(16*b + j));
            dexp[127 - 8*j -: 8] = 8'(16*b + j);
         end
         run_block(4, din, dexp, 4, $sformatf("sweep %0d", b));
      end

      // Backpressure with noisy input side
      for (int j = 0; j < 16; j++) begin
         din[127 - 8*j -: 8]  = fsbox(8'(8'hc3 ^ 8'(j*29)));
         dexp[127 - 8*j -: 8] = 8'hc3 ^ 8'(j*29);
      end
      drv(4, 1'b1, din, 1'b0);
      tick();
      drv(4, 1'b0, din, 1'b0);
      w = 0;
      while (!vld(4) && w < 50) begin tick(); w++; end
      chk("bp valid", 128'(vld(4)), 128'd1);
      for (int i = 0; i < 10; i++) begin
         drv(4, i[0], {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
         tick();
         chk("bp hold valid", 128'(vld(4)), 128'd1);
         chk("bp hold ready", 128'(rdy(4)), 128'd0);
         chk("bp hold data", dat(4), dexp);
      end
      drv(4, 1'b0, din, 1'b1);
      tick();
      chk("bp release", {126'd0, vld(4), rdy(4)}, 128'd1);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin tick(); if (vld(4)) seen = 1'b1; end
      chk("bp no second block", 128'(seen), 128'd0);

      // Back-to-back with continuous valid
      t = 0; nacc = 0; nout = 0;
      drv(4, 1'b1, {16{fsbox(8'h05)}}, 1'b1);
      while (nout < 5 && t < 100) begin
         acc = rdy(4) && (nacc < 5);
         if (vld(4)) begin
            if (expq.size() > 0) chk("b2b data", dat(4), expq.pop_front());
            else chk("b2b spurious output", 128'd1, 128'd0);
            nout++;
         end
         tick();
         t++;
         if (acc) begin
            acc_t.push_back(t);
            expq.push_back({16{8'(nacc*37 + 5)}});
            nacc++;
            drv(4, nacc < 5, {16{fsbox(8'(nacc*37 + 5))}}, 1'b1);
         end
      end
      chk("b2b outputs", 128'(nout), 128'd5);
      chk("b2b accepts", 128'(acc_t.size()), 128'd5);
      for (int i = 1; i < acc_t.size(); i++) chk("b2b spacing", 128'(acc_t[i] - acc_t[i-1]), 128'd6);
      drv(4, 1'b0, '0, 1'b1);
      tick(); tick();

      // Reset two cycles after an accept
      drv(4, 1'b1, c_known_in, 1'b1);
      tick();
      drv(4, 1'b0, '0, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst idle", {126'd0, vld(4), rdy(4)}, 128'd1);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin tick(); if (vld(4)) seen = 1'b1; end
      chk("midrst no valid", 128'(seen), 128'd0);
      run_block(4, {16{8'h16}}, {16{8'hff}}, 4, "after midrst");

      // Lane-count variants
      run_block(1, c_known_in, c_known_exp, 16, "known L1");
      run_block(16, c_known_in, c_known_exp, 1, "known L16");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
`default_nettype wire
